// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of sram_ctrl; port 1 may hold the bus for up to BURST_LEN grants.
// Define SRAM_ARB_FIXED_PRIO_EN to make port 0 win every tie and drop the burst counter.
module sram_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m1_req_i,
    input  logic              m0_write_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [3:0]        m0_byteSelect_i,
    input  logic [3:0]        m1_byteSelect_i,
    input  logic [31:0]       m0_dataSave_i,
    input  logic [31:0]       m1_dataSave_i,
    output logic              m0_ack_o,
    output logic              m1_ack_o,
    output logic              m0_busy_o,
    output logic              m1_busy_o,
    output logic [31:0]       m0_dataLoad_o,
    output logic [31:0]       m1_dataLoad_o,
    output logic              enable_o,
    output logic              readEnable_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [3:0]        byteSelect_o,
    output logic [31:0]       dataSave_o,
    input  logic [31:0]       dataLoad_i,
    input  logic              busy_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    state_t            state_reg, state_next;
    logic              write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        byte_sel_reg;
    logic [31:0]       data_save_reg;
    logic              win_valid, win_port;

    logic [1:0]        req_vec, write_vec, ack_vec;
    logic [ADDR_W-1:0] addr_arr      [2];
    logic [3:0]        byte_sel_arr  [2];
    logic [31:0]       data_save_arr [2];
    logic [31:0]       data_load_arr [2];

    assign req_vec          = {m1_req_i, m0_req_i};
    assign write_vec        = {m1_write_i, m0_write_i};
    assign addr_arr[0]      = m0_addr_i;
    assign addr_arr[1]      = m1_addr_i;
    assign byte_sel_arr[0]  = m0_byteSelect_i;
    assign byte_sel_arr[1]  = m1_byteSelect_i;
    assign data_save_arr[0] = m0_dataSave_i;
    assign data_save_arr[1] = m1_dataSave_i;

`ifndef SRAM_ARB_FIXED_PRIO_EN
    localparam logic [3:0] BURST_LEN_C = 4'(BURST_LEN);
    logic       last_reg;
    logic [3:0] burst_cnt_reg;
`endif

    always_comb begin
        win_valid = |req_vec;
        win_port  = 1'b0;
        if (&req_vec) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            win_port = 1'b0;
`else
            // burst_cnt is zero only straight after reset, where port 0 takes the first tie
            if (last_reg && (burst_cnt_reg != 4'd0) && (burst_cnt_reg < BURST_LEN_C))
                win_port = 1'b1;
            else
                win_port = ~last_reg;
`endif
        end else begin
            win_port = req_vec[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (win_valid) state_next = win_port ? GNT1 : GNT0;
            GNT0, GNT1: if (!busy_i)   state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            byte_sel_reg  <= 4'd0;
            data_save_reg <= 32'd0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_reg      <= 1'b1;
            burst_cnt_reg <= 4'd0;
`endif
        end else if (state_reg == IDLE && win_valid) begin
            write_reg     <= write_vec[win_port];
            addr_reg      <= addr_arr[win_port];
            byte_sel_reg  <= byte_sel_arr[win_port];
            data_save_reg <= data_save_arr[win_port];
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_reg      <= win_port;
            if (!win_port)                  burst_cnt_reg <= 4'd0;
            else if (burst_cnt_reg != 4'hF) burst_cnt_reg <= burst_cnt_reg + 4'd1;
`endif
        end
    end

    always_comb begin
        enable_o     = (state_reg == GNT0) || (state_reg == GNT1);
        readEnable_o = enable_o && !write_reg;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam state_t GNT_ST = (gi == 0) ? GNT0 : GNT1;
            assign ack_vec[gi]       = (state_reg == GNT_ST) && !busy_i;
            assign data_load_arr[gi] = ack_vec[gi] ? dataLoad_i : 32'd0;
        end
    endgenerate

    assign m0_ack_o      = ack_vec[0];
    assign m1_ack_o      = ack_vec[1];
    assign m0_busy_o     = m0_req_i & ~ack_vec[0];
    assign m1_busy_o     = m1_req_i & ~ack_vec[1];
    assign m0_dataLoad_o = data_load_arr[0];
    assign m1_dataLoad_o = data_load_arr[1];
    assign addr_o        = addr_reg;
    assign byteSelect_o  = byte_sel_reg;
    assign dataSave_o    = data_save_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level model checked every cycle, directed cases, random traffic.
module tb_sram_arbiter;
    localparam int BL = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        m0_req = 0, m1_req = 0, m0_write = 0, m1_write = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_ds = 0, m1_ds = 0, dl_in = 0;
    logic [3:0]  m0_bs = 0, m1_bs = 0;
    logic        busy_in = 0;

    logic        m0_ack, m1_ack, m0_busy, m1_busy, en, re;
    logic [31:0] m0_dl, m1_dl, addr_out, ds_out;
    logic [3:0]  bs_out;
    logic        m0_ack_b, m1_ack_b, m0_busy_b, m1_busy_b, en_b, re_b;
    logic [31:0] m0_dl_b, m1_dl_b, addr_out_b, ds_out_b;
    logic [3:0]  bs_out_b;

    int errors = 0, checks = 0;
    int log_a[$], log_b[$];

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(32), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m1_req_i(m1_req), .m0_write_i(m0_write), .m1_write_i(m1_write),
        .m0_addr_i(m0_addr), .m1_addr_i(m1_addr), .m0_byteSelect_i(m0_bs), .m1_byteSelect_i(m1_bs),
        .m0_dataSave_i(m0_ds), .m1_dataSave_i(m1_ds),
        .m0_ack_o(m0_ack), .m1_ack_o(m1_ack), .m0_busy_o(m0_busy), .m1_busy_o(m1_busy),
        .m0_dataLoad_o(m0_dl), .m1_dataLoad_o(m1_dl),
        .enable_o(en), .readEnable_o(re), .addr_o(addr_out), .byteSelect_o(bs_out),
        .dataSave_o(ds_out), .dataLoad_i(dl_in), .busy_i(busy_in));

    sram_arbiter #(.ADDR_W(32), .BURST_LEN(1)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m1_req_i(m1_req), .m0_write_i(m0_write), .m1_write_i(m1_write),
        .m0_addr_i(m0_addr), .m1_addr_i(m1_addr), .m0_byteSelect_i(m0_bs), .m1_byteSelect_i(m1_bs),
        .m0_dataSave_i(m0_ds), .m1_dataSave_i(m1_ds),
        .m0_ack_o(m0_ack_b), .m1_ack_o(m1_ack_b), .m0_busy_o(m0_busy_b), .m1_busy_o(m1_busy_b),
        .m0_dataLoad_o(m0_dl_b), .m1_dataLoad_o(m1_dl_b),
        .enable_o(en_b), .readEnable_o(re_b), .addr_o(addr_out_b), .byteSelect_o(bs_out_b),
        .dataSave_o(ds_out_b), .dataLoad_i(dl_in), .busy_i(busy_in));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Model: which port owns the bus (-1 = none), who was served last, and how long port 1's current run is.
    int          m_serv = -1, m_last = 1, m_run = 0, m_w = 0;
    logic        m_write = 0;
    logic [31:0] m_addr = 0, m_ds = 0;
    logic [3:0]  m_bs = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_serv = -1; m_last = 1; m_run = 0;
            m_write = 0; m_addr = 0; m_ds = 0; m_bs = 0;
        end else if (m_serv >= 0) begin
            if (!busy_in) m_serv = -1;
        end else if (m0_req || m1_req) begin
            if (m0_req && m1_req) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                m_w = 0;
`else
                if (m_run > 0 && m_run < BL)      m_w = 1;
                else if (m_run == 0 && m_last == 0) m_w = 1;
                else                               m_w = 0;
`endif
            end else begin
                m_w = m1_req ? 1 : 0;
            end
            m_serv = m_w; m_last = m_w;
            m_run  = m_w ? m_run + 1 : 0;
            m_write = m_w ? m1_write : m0_write;
            m_addr  = m_w ? m1_addr  : m0_addr;
            m_bs    = m_w ? m1_bs    : m0_bs;
            m_ds    = m_w ? m1_ds    : m0_ds;
        end
    end

    always @(negedge clk) begin
        logic e_ack0, e_ack1;
        #2;
        e_ack0 = (m_serv == 0) && !busy_in;
        e_ack1 = (m_serv == 1) && !busy_in;
        chk("enable",     32'(en),      32'(m_serv >= 0));
        chk("readEnable", 32'(re),      32'((m_serv >= 0) && !m_write));
        chk("addr",       addr_out,     m_addr);
        chk("byteSelect", 32'(bs_out),  32'(m_bs));
        chk("dataSave",   ds_out,       m_ds);
        chk("m0_ack",     32'(m0_ack),  32'(e_ack0));
        chk("m1_ack",     32'(m1_ack),  32'(e_ack1));
        chk("m0_dataLoad", m0_dl,       e_ack0 ? dl_in : 32'd0);
        chk("m1_dataLoad", m1_dl,       e_ack1 ? dl_in : 32'd0);
        chk("m0_busy",    32'(m0_busy), 32'(m0_req && !e_ack0));
        chk("m1_busy",    32'(m1_busy), 32'(m1_req && !e_ack1));
        if (m0_ack) begin log_a.push_back(0); $display("txn port=0 we=%0b addr=%h", m_write, m_addr); end
        if (m1_ack) begin log_a.push_back(1); $display("txn port=1 we=%0b addr=%h", m_write, m_addr); end
        if (m0_ack_b) log_b.push_back(0);
        if (m1_ack_b) log_b.push_back(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int exp_a[11], exp_b[4], waited;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_a = '{0,0,0,0,0,0,0,0,0,0,0};
        exp_b = '{0,0,0,0};
`else
        exp_a = '{0,1,1,1,1,0,1,1,1,1,0};
        exp_b = '{0,1,0,1};
`endif
        cyc(2); #2;
        chk("reset enable", 32'(en), 32'd0);
        chk("reset addr", addr_out, 32'd0);
        @(negedge clk); rst = 0;

        // single read on port 0
        @(negedge clk);
        m0_req = 1; m0_write = 0; m0_addr = 32'h100; dl_in = 32'hDEADBEEF; busy_in = 0;
        #2 chk("t1 busy before grant", 32'(m0_busy), 32'd1);
        @(negedge clk); #2;
        chk("t1 enable", 32'(en), 32'd1);
        chk("t1 readEnable", 32'(re), 32'd1);
        chk("t1 addr", addr_out, 32'h100);
        chk("t1 ack", 32'(m0_ack), 32'd1);
        chk("t1 dataLoad", m0_dl, 32'hDEADBEEF);
        @(negedge clk); m0_req = 0;
        #2 chk("t1 busy after ack", 32'(m0_busy), 32'd0);

        // stretched write on port 1
        @(negedge clk);
        m1_req = 1; m1_write = 1; m1_addr = 32'h20; m1_ds = 32'h12345678; m1_bs = 4'h3; busy_in = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #2;
            chk("t2 enable held", 32'(en), 32'd1);
            chk("t2 readEnable", 32'(re), 32'd0);
            chk("t2 addr held", addr_out, 32'h20);
            chk("t2 data held", ds_out, 32'h12345678);
            chk("t2 bs held", 32'(bs_out), 32'h3);
            chk("t2 no early ack", 32'(m1_ack), 32'd0);
        end
        @(negedge clk); busy_in = 0;
        #2 chk("t2 ack 4th cycle", 32'(m1_ack), 32'd1);
        chk("t2 readEnable at ack", 32'(re), 32'd0);
        @(negedge clk); m1_req = 0; m1_write = 0;

        // reset while port 0 is stretched
        @(negedge clk); m0_req = 1; m0_addr = 32'h40; busy_in = 1;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; m0_req = 0; busy_in = 0;
        #2 chk("t3 enable after reset", 32'(en), 32'd0);
        chk("t3 no ack", 32'(m0_ack), 32'd0);
        @(negedge clk); m0_req = 1;
        waited = 0;
        do begin @(negedge clk); #2; waited++; end while (!m0_ack && waited < 10);
        chk("t3 re-request ack", 32'(m0_ack), 32'd1);
        @(negedge clk); m0_req = 0;

        // grant order with both ports requesting continuously from reset
        rst = 1; cyc(2); rst = 0; log_a.delete(); log_b.delete();
        m0_req = 1; m1_req = 1; busy_in = 0;
        cyc(24);
        m0_req = 0; m1_req = 0;
        chk("order count", 32'(log_a.size() >= 11), 32'd1);
        for (int i = 0; i < 11; i++)
            chk($sformatf("order A[%0d]", i), 32'(i < log_a.size() ? log_a[i] : -1), 32'(exp_a[i]));
        for (int i = 0; i < 4; i++)
            chk($sformatf("order B1[%0d]", i), 32'(i < log_b.size() ? log_b[i] : -1), 32'(exp_b[i]));

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 99) == 0);
            m0_req   = ($urandom_range(0, 9) < 6);
            m1_req   = ($urandom_range(0, 9) < 7);
            m0_write = $urandom_range(0, 1);
            m1_write = $urandom_range(0, 1);
            m0_addr  = $urandom; m1_addr = $urandom;
            m0_ds    = $urandom; m1_ds   = $urandom;
            m0_bs    = 4'($urandom); m1_bs = 4'($urandom);
            busy_in  = ($urandom_range(0, 9) < 4);
            dl_in    = $urandom;
        end
        @(negedge clk); rst = 0; m0_req = 0; m1_req = 0;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
